stream_packetizer: RTL and testbench
====================================

Name: stream_packetizer

Overview:
Downstream consumer of the valid/ready word FIFO. Reads raw DataWidth-bit words and frames them into fixed-length packets: a header word carrying a sequence number, then PktLen payload words, then an XOR checksum word flagged with dout_last_o. The output is fully registered and holds under backpressure, so the next stage sees a clean valid/ready stream with packet boundaries.

Parameters:
DataWidth, 16, width of input and output words
PktLen, 4, payload words per packet; legal range 1..65535
SeqWidth, 8, sequence-number width; must be <= DataWidth

Ports:
clk_i  input  1  clock; all logic on the rising edge
arst_ni  input  1  asynchronous active-low reset
din_i  input  DataWidth  input word from the FIFO
din_val_i  input  1  din_i is valid
din_rdy_o  output  1  block accepts din_i this cycle
dout_o  output  DataWidth  output word: header, payload or checksum
dout_val_o  output  1  dout_o is valid
dout_rdy_i  input  1  downstream accepts dout_o
dout_last_o  output  1  high with the checksum word, the last word of a packet
pkt_cnt_o  output  16  completed packets delivered; wraps at 2^16

Behaviour:
- Reset is arst_ni, asynchronous, active-low; clock is clk_i.
- Reset values: dout_o=0, dout_val_o=0, dout_last_o=0, pkt_cnt_o=0, state=IDLE, seq=0, checksum=0, payload count=0.
- Handshakes: input transfer when din_val_i && din_rdy_o; output transfer when dout_val_o && dout_rdy_i.
- slot_free = !dout_val_o || dout_rdy_i. The output register loads only when slot_free.
- While dout_val_o && !dout_rdy_i, dout_o and dout_last_o are held stable.
- If slot_free and nothing loads, dout_val_o goes to 0 on the next edge.
- din_rdy_o = (state==PAYLOAD) && slot_free. This is combinational from dout_rdy_i by design. din_rdy_o is 0 in IDLE and CSUM.
- State IDLE: when din_val_i=1 and slot_free:
  - load dout_o = seq zero-extended to DataWidth, dout_last_o=0, dout_val_o=1
  - clear checksum and payload count
  - go to PAYLOAD
  - no input word is consumed
- State PAYLOAD: on each input transfer:
  - load dout_o = din_i, dout_last_o=0
  - checksum ^= din_i, count++
  - on the transfer with count==PktLen-1, go to CSUM
- State CSUM: when slot_free:
  - load dout_o = final checksum (including the last payload word), dout_last_o=1
  - seq <= seq+1, wrapping modulo 2^SeqWidth
  - go to IDLE
- pkt_cnt_o increments by 1 on each output transfer with dout_last_o=1.
- Latency: the header is valid the cycle after din_val_i is first seen in IDLE. Each payload word appears the cycle after its input transfer.
- Throughput: with no stalls, a packet takes PktLen+2 cycles, and the next header may follow the checksum back-to-back.
- Input gaps (din_val_i low in PAYLOAD): the block waits indefinitely with no timeout and no padding; dout_val_o drops once the last word drains.
- PktLen=1: the packet is header, one word, checksum; the checksum equals that word.
- Reset mid-packet: the partial packet is discarded. The next packet starts in IDLE with seq=0. Words already consumed are lost by design.

Test Plan:
- Reset: assert arst_ni=0 asynchronously mid-cycle -> dout_val_o=0, dout_o=0, dout_last_o=0, din_rdy_o=0, pkt_cnt_o=0 immediately.
- Basic packet (PktLen=4, dout_rdy_i=1): input 0x1111, 0x2222, 0x4444, 0x8888 -> output 0x0000, 0x1111, 0x2222, 0x4444, 0x8888, 0xFFFF on consecutive cycles; last=1 only on 0xFFFF; pkt_cnt_o=1.
- Sequence wrap: 257 back-to-back packets -> headers 0x0000..0x00FF then 0x0000; 6 cycles per packet; pkt_cnt_o=257.
- Backpressure: dout_rdy_i=0 for 3 cycles while 0x2222 is on dout_o -> 0x2222 held, din_rdy_o=0, no FIFO word lost or duplicated; the stream resumes in order.
- Gapped input: din_val_i alternating 1/0 with the basic-packet data -> identical output word sequence and checksum 0xFFFF; dout_val_o drops during the gaps.
- Reset mid-packet after header, 0x1111 and 0x2222 are delivered -> dout_val_o=0. The next packet of 0xAAAA, 0x5555, 0x0001, 0x0002 yields header 0x0000 and checksum 0xFFFC.

Source files
------------

// File: rtl/stream_packetizer.sv
// Frames a valid/ready word stream into packets: header (sequence number),
// PktLen payload words, then an XOR checksum word marked with dout_last_o.
module stream_packetizer #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned PktLen    = 4,
  parameter int unsigned SeqWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic [DataWidth-1:0] din_i,
  input  logic                 din_val_i,
  output logic                 din_rdy_o,
  output logic [DataWidth-1:0] dout_o,
  output logic                 dout_val_o,
  input  logic                 dout_rdy_i,
  output logic                 dout_last_o,
  output logic [15:0]          pkt_cnt_o
);

  // Handshake rules: a word moves on either side only in a cycle where
  // valid && ready is seen at the rising edge; valid never depends on ready.
  typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM} state_e;

  localparam logic [15:0] LastIdx = 16'(PktLen - 1);

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  dout_q, dout_d;
  logic                  dout_val_q, dout_val_d;
  logic                  dout_last_q, dout_last_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic [SeqWidth-1:0]   seq_q, seq_d;
  logic [DataWidth-1:0]  csum_q, csum_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  slot_free;

  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    dout_val_d  = dout_val_q;
    dout_last_d = dout_last_q;
    pkt_cnt_d   = pkt_cnt_q;
    seq_d       = seq_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;

    slot_free = !dout_val_q || dout_rdy_i;
    din_rdy_o = (state_q == PAYLOAD) && slot_free;

    // An emptied slot with nothing new to load drops valid.
    if (slot_free) dout_val_d = 1'b0;

    if (dout_val_q && dout_rdy_i && dout_last_q) pkt_cnt_d = pkt_cnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (din_val_i && slot_free) begin
          dout_d      = DataWidth'(seq_q);
          dout_last_d = 1'b0;
          dout_val_d  = 1'b1;
          csum_d      = '0;
          cnt_d       = '0;
          state_d     = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (din_val_i && din_rdy_o) begin
          dout_d      = din_i;
          dout_last_d = 1'b0;
          dout_val_d  = 1'b1;
          csum_d      = csum_q ^ din_i;
          cnt_d       = cnt_q + 16'd1;
          if (cnt_q == LastIdx) state_d = CSUM;
        end
      end
      CSUM: begin
        if (slot_free) begin
          dout_d      = csum_q;
          dout_last_d = 1'b1;
          dout_val_d  = 1'b1;
          seq_d       = seq_q + SeqWidth'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      dout_q      <= '0;
      dout_val_q  <= 1'b0;
      dout_last_q <= 1'b0;
      pkt_cnt_q   <= '0;
      seq_q       <= '0;
      csum_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      dout_val_q  <= dout_val_d;
      dout_last_q <= dout_last_d;
      pkt_cnt_q   <= pkt_cnt_d;
      seq_q       <= seq_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dout_o      = dout_q;
  assign dout_val_o  = dout_val_q;
  assign dout_last_o = dout_last_q;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed bench for stream_packetizer: expected words queued by the driver,
// popped and compared by an independent output monitor.
module tb_stream_packetizer;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic [15:0] din_i = '0;
  logic        din_val_i = 1'b0;
  logic        din_rdy_o;
  logic [15:0] dout_o;
  logic        dout_val_o;
  logic        dout_rdy_i = 1'b1;
  logic        dout_last_o;
  logic [15:0] pkt_cnt_o;

  stream_packetizer #(.DataWidth(16), .PktLen(4), .SeqWidth(8)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .din_i       (din_i),
    .din_val_i   (din_val_i),
    .din_rdy_o   (din_rdy_o),
    .dout_o      (dout_o),
    .dout_val_o  (dout_val_o),
    .dout_rdy_i  (dout_rdy_i),
    .dout_last_o (dout_last_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Scoreboard state: entries are {last, word}
  logic [16:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  seq_model = '0;
  int          cyc = 0;
  logic        hdr_next = 1'b1;
  logic        rate_chk = 1'b0;
  logic        have_prev = 1'b0;
  int          prev_hdr_cyc = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Output monitor: a transfer happens at the next rising edge.
  always @(negedge clk_i) begin
    if (arst_ni && dout_val_o && dout_rdy_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h last %0b expected nothing", dout_o, dout_last_o);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("out_word", {15'd0, dout_last_o, dout_o}, {15'd0, e});
        if (hdr_next) begin
          if (rate_chk && have_prev) chk("hdr_spacing", cyc - prev_hdr_cyc, 6);
          prev_hdr_cyc = cyc;
          have_prev    = 1'b1;
        end
        hdr_next = e[16];
      end
    end
  end

  // Driver tasks
  task automatic apply_reset();
    @(posedge clk_i);
    #3 arst_ni = 1'b0;
    #1;
    chk("rst_dout_val", dout_val_o, 0);
    chk("rst_dout", dout_o, 0);
    chk("rst_last", dout_last_o, 0);
    chk("rst_din_rdy", din_rdy_o, 0);
    chk("rst_pkt_cnt", pkt_cnt_o, 0);
    exp_q.delete();
    seq_model = '0;
    hdr_next  = 1'b1;
    din_val_i = 1'b0;
    dout_rdy_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #3 arst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w, input int gap, input logic chk_gap);
    int n;
    din_i     = w;
    din_val_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!din_rdy_o && n < 100);
    if (n >= 100) chk("din_rdy_timeout", 0, 1);
    @(posedge clk_i);
    #1 din_val_i = 1'b0;
    if (gap > 0) begin
      @(posedge clk_i);
      #1;
      if (chk_gap) chk("gap_val_drop", dout_val_o, 0);
      repeat (gap - 1) @(posedge clk_i);
      if (gap > 1) #1;
    end
  endtask

  task automatic send_packet(input logic [15:0] w[4], input int gap, input logic [15:0] csum);
    exp_q.push_back({1'b0, 8'd0, seq_model});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, w[i]});
    exp_q.push_back({1'b1, csum});
    seq_model = seq_model + 8'd1;
    for (int i = 0; i < 4; i++) push_word(w[i], gap, (gap > 0) && (i < 3));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || dout_val_o) && n < 300) begin
      @(posedge clk_i);
      #1 n++;
    end
    chk("drain_timeout", (n < 300) ? 1 : 0, 1);
  endtask

  logic [15:0] basic_w[4];
  logic [15:0] alt_w[4];

  initial begin
    basic_w[0] = 16'h1111; basic_w[1] = 16'h2222;
    basic_w[2] = 16'h4444; basic_w[3] = 16'h8888;
    alt_w[0] = 16'hAAAA; alt_w[1] = 16'h5555;
    alt_w[2] = 16'h0001; alt_w[3] = 16'h0002;

    apply_reset();

    // Basic packet
    send_packet(basic_w, 0, 16'hFFFF);
    wait_drain();
    chk("pkt_cnt_basic", pkt_cnt_o, 1);

    // Backpressure on 0x2222 for three cycles
    fork
      send_packet(basic_w, 0, 16'hFFFF);
      begin
        int n = 0;
        do begin
          @(posedge clk_i);
          #1 n++;
        end while (!(dout_val_o && dout_o == 16'h2222) && n < 50);
        chk("bp_seen", (n < 50) ? 1 : 0, 1);
        dout_rdy_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk_i);
          #1;
          chk("bp_hold_word", dout_o, 16'h2222);
          chk("bp_hold_val", dout_val_o, 1);
          chk("bp_din_rdy", din_rdy_o, 0);
        end
        dout_rdy_i = 1'b1;
      end
    join
    wait_drain();
    chk("pkt_cnt_bp", pkt_cnt_o, 2);

    // Gapped input
    send_packet(basic_w, 1, 16'hFFFF);
    wait_drain();
    chk("pkt_cnt_gap", pkt_cnt_o, 3);

    // Reset mid-packet after header, 0x1111 and 0x2222 delivered
    exp_q.push_back({1'b0, 8'd0, seq_model});
    exp_q.push_back({1'b0, 16'h1111});
    exp_q.push_back({1'b0, 16'h2222});
    push_word(16'h1111, 0, 1'b0);
    push_word(16'h2222, 0, 1'b0);
    wait_drain();
    chk("mid_val_low", dout_val_o, 0);
    apply_reset();
    send_packet(alt_w, 0, 16'hFFFC);
    wait_drain();
    chk("pkt_cnt_after_rst", pkt_cnt_o, 1);

    // Sequence wrap: 257 back-to-back packets
    apply_reset();
    have_prev = 1'b0;
    rate_chk  = 1'b1;
    for (int p = 0; p < 257; p++) send_packet(basic_w, 0, 16'hFFFF);
    wait_drain();
    rate_chk = 1'b0;
    chk("pkt_cnt_wrap", pkt_cnt_o, 257);
    chk("seq_model_wrap", {24'd0, seq_model}, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
